i_arith_seq_decoder: RTL and testbench

I_ARITH_SEQ_DECODER -- requirements
Module: i_arith_seq_decoder

---
 rtl/i_arith_seq_decoder_pkg.sv | 32 +++
 rtl/i_arith_cw_pack.sv | 94 +++++++++
 rtl/i_arith_seq_decoder.sv | 85 ++++++++
 tb/tb_i_arith_seq_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/i_arith_seq_decoder_pkg.sv
// Shared encodings for the immediate-arithmetic decoder: ALU/PC function codes,
// instruction class opcodes, the NOP control word and the handshake FSM states.
package i_arith_seq_decoder_pkg;

  // instr[28:23] class opcodes
  localparam logic [5:0] OPC_ARITH = 6'b100010;
  localparam logic [5:0] OPC_LOGIC = 6'b100100;

  // alu_fs encodings
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;

  // pc_fs encodings and next-state code
  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01;
  localparam logic [1:0] NS_FETCH   = 2'b00;

  localparam int unsigned IMM_SHIFT = 12;

  // Low byte of the control word {ram_w, db_pc_en, pc_fs, pc_isel, status_load, ns};
  // every field above it is zero in a NOP, so this byte zero-extended is the whole NOP.
  localparam logic [7:0] CW_NOP_LOW = {1'b0, 1'b0, PC_FS_INC, 1'b1, 1'b0, NS_FETCH};

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/i_arith_cw_pack.sv
// Combinational decode of one instruction word into {ctrl_word, k, illegal}.
// Macro I_ARITH_SHIFT_EN enables the imm<<12 form of the arithmetic class.
module i_arith_cw_pack
  import i_arith_seq_decoder_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 12,
  parameter int CW_W   = 18 + 3 * REG_AW
) (
  input  logic [31:0]       instr,
  output logic [CW_W-1:0]   ctrl_word,
  output logic [DATA_W-1:0] k,
  output logic              illegal
);

  logic              is_arith;
  logic              is_logic;
  logic              shift_bit;
  logic [IMM_W-1:0]  imm;
  logic [REG_AW-1:0] sa;
  logic [REG_AW-1:0] wa;
  logic              unused_sf;

  logic              legal;
  logic [4:0]        alu_fs;
  logic              status_load;
  logic              rf_w;
  logic [CW_W-1:0]   cw_alu;

  assign is_arith  = (instr[28:23] == OPC_ARITH);
  assign is_logic  = (instr[28:23] == OPC_LOGIC);
  assign shift_bit = instr[22];
  assign imm       = instr[10 +: IMM_W];
  assign sa        = instr[5 +: REG_AW];
  assign wa        = instr[0 +: REG_AW];
  assign unused_sf = instr[31];

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    legal       = 1'b0;
    alu_fs      = FS_AND;
    status_load = 1'b0;
    k           = '0;

    if (is_arith) begin
      alu_fs      = instr[30] ? FS_SUB : FS_ADD;
      status_load = instr[29];
`ifdef I_ARITH_SHIFT_EN
      legal = 1'b1;
      k     = shift_bit ? DATA_W'({imm, {IMM_SHIFT{1'b0}}}) : DATA_W'(imm);
`else
      legal = !shift_bit;
      k     = shift_bit ? '0 : DATA_W'(imm);
`endif
    end else if (is_logic && !shift_bit) begin
      // Logical immediates have no shifted form, so instr[22]=1 stays illegal here.
      legal = 1'b1;
      k     = DATA_W'(imm);
      unique case (instr[30:29])
        2'b00:   alu_fs = FS_AND;
        2'b01:   alu_fs = FS_ORR;
        2'b10:   alu_fs = FS_EOR;
        default: begin
          alu_fs      = FS_AND;
          status_load = 1'b1;
        end
      endcase
    end
  end

  // Flag-setting forms that target the all-ones register only update flags.
  assign rf_w = !(status_load && (wa == {REG_AW{1'b1}}));

  assign cw_alu = {1'b1,            // alu_en
                   1'b1,            // alu_bs
                   alu_fs,
                   1'b0,            // db_rfb_en
                   sa,
                   {REG_AW{1'b0}},  // sb
                   wa,
                   rf_w,
                   1'b0,            // db_ram_en
                   1'b0,            // ram_w
                   1'b0,            // db_pc_en
                   PC_FS_INC,
                   1'b1,            // pc_isel
                   status_load,
                   NS_FETCH};

  assign ctrl_word = legal ? cw_alu : CW_W'(CW_NOP_LOW);
  assign illegal   = !legal;

endmodule

// File: rtl/i_arith_seq_decoder.sv
// Single-entry registered decoder for immediate ALU instructions with a
// valid/ready handshake on both sides. Optional macro: I_ARITH_SHIFT_EN.
module i_arith_seq_decoder
  import i_arith_seq_decoder_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int REG_AW = 5,
  parameter  int IMM_W  = 12,
  localparam int CW_W   = 18 + 3 * REG_AW
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [CW_W-1:0]   ctrl_word,
  output logic [DATA_W-1:0] k,
  output logic              illegal,
  output logic [15:0]       uop_count
);

  state_e            state;
  state_e            state_nxt;
  logic              accept;

  logic [CW_W-1:0]   dec_cw;
  logic [DATA_W-1:0] dec_k;
  logic              dec_illegal;

  i_arith_cw_pack #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .IMM_W  (IMM_W),
    .CW_W   (CW_W)
  ) u_cw_pack (
    .instr     (instr),
    .ctrl_word (dec_cw),
    .k         (dec_k),
    .illegal   (dec_illegal)
  );

  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (cw_ready && !accept) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Output register is bypass-free: a new word may load in the same cycle the old one drains.
  always_comb begin
    cw_valid = (state == ST_FULL);
    in_ready = !cw_valid || cw_ready;
  end

  // NOTE: the held word is reset too, so ctrl_word/k/illegal read zero after reset rather than X.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_word <= '0;
      k         <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      ctrl_word <= dec_cw;
      k         <= dec_k;
      illegal   <= dec_illegal;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    uop_count <= '0;
    else if (accept) uop_count <= uop_count + 16'd1;
  end

endmodule

// File: tb/tb_i_arith_seq_decoder.sv
// Directed bench for i_arith_seq_decoder: expected words are pushed to a
// scoreboard at accept and compared while the DUT presents them.
module tb_i_arith_seq_decoder;

  localparam logic [5:0] ARITH = 6'b100010;
  localparam logic [5:0] LOGIC = 6'b100100;
  localparam logic [4:0] F_ADD = 5'b01000;
  localparam logic [4:0] F_SUB = 5'b01010;
  localparam logic [4:0] F_AND = 5'b00000;
  localparam logic [4:0] F_ORR = 5'b00100;
  localparam logic [4:0] F_EOR = 5'b01100;
  localparam logic [32:0] NOP_CW = 33'h0_0000_0018;

  typedef struct {
    logic [32:0] cw;
    logic [63:0] k;
    logic        ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        cw_valid;
  logic        cw_ready = 1'b0;
  logic [32:0] ctrl_word;
  logic [63:0] k;
  logic        illegal;
  logic [15:0] uop_count;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        model_full = 1'b0;
  logic [15:0] model_cnt = '0;

  i_arith_seq_decoder dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .cw_valid  (cw_valid),
    .cw_ready  (cw_ready),
    .ctrl_word (ctrl_word),
    .k         (k),
    .illegal   (illegal),
    .uop_count (uop_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] enc(input logic op, input logic s, input logic [5:0] cls,
                                      input logic sh, input logic [11:0] imm,
                                      input logic [4:0] rn, input logic [4:0] rd);
    return {1'b1, op, s, cls, sh, imm, rn, rd};
  endfunction

  function automatic exp_t alu_exp(input logic [4:0] fs, input logic sl, input logic [4:0] sa,
                                   input logic [4:0] wa, input logic rf_w, input logic [63:0] kv);
    exp_t e;
    e.cw  = {1'b1, 1'b1, fs, 1'b0, sa, 5'd0, wa, rf_w, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, sl, 2'b00};
    e.k   = kv;
    e.ill = 1'b0;
    return e;
  endfunction

  function automatic exp_t nop_exp();
    exp_t e;
    e.cw  = NOP_CW;
    e.k   = '0;
    e.ill = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: drive inputs, check handshake and presented word, then advance past the edge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] ins,
                       input logic rdy, input exp_t e);
    logic acc;
    logic con;
    exp_t f;
    in_valid = v;
    instr    = ins;
    cw_ready = rdy;
    #1;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(!model_full || rdy));
    check({tag, ".cw_valid"}, 64'(cw_valid), 64'(model_full));
    if (model_full) begin
      check({tag, ".sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        f = sb[0];
        check({tag, ".ctrl_word"}, 64'(ctrl_word), 64'(f.cw));
        check({tag, ".k"}, k, f.k);
        check({tag, ".illegal"}, 64'(illegal), 64'(f.ill));
      end
    end
    acc = v && (!model_full || rdy);
    con = model_full && rdy;
    if (con && sb.size() > 0) void'(sb.pop_front());
    if (acc) begin
      sb.push_back(e);
      model_cnt = model_cnt + 16'd1;
    end
    model_full = acc || (model_full && !rdy);
    @(posedge clock);
    #1;
    check({tag, ".uop_count"}, 64'(uop_count), 64'(model_cnt));
  endtask

  initial begin
    exp_t        e;
    exp_t        idle;
    logic [31:0] w;
    idle = nop_exp();

    // Reset state
    #12;
    check("rst.cw_valid", 64'(cw_valid), 64'd0);
    check("rst.ctrl_word", 64'(ctrl_word), 64'd0);
    check("rst.k", k, 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    check("rst.uop_count", 64'(uop_count), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;

    // ADDI Rn=3 Rd=4 imm=5
    cycle("addi", 1'b1, enc(1'b0, 1'b0, ARITH, 1'b0, 12'd5, 5'd3, 5'd4), 1'b1,
          alu_exp(F_ADD, 1'b0, 5'd3, 5'd4, 1'b1, 64'd5));
    check("addi.uop_is_1", 64'(uop_count), 64'd1);
    cycle("addi_out", 1'b0, '0, 1'b1, idle);

    // SUBS to the all-ones register: compare form, no register write
    cycle("subs", 1'b1, enc(1'b1, 1'b1, ARITH, 1'b0, 12'hFFF, 5'd1, 5'd31), 1'b1,
          alu_exp(F_SUB, 1'b1, 5'd1, 5'd31, 1'b0, 64'hFFF));
    // ADDS with ordinary destination keeps rf_w, streamed behind SUBS
    cycle("adds", 1'b1, enc(1'b0, 1'b1, ARITH, 1'b0, 12'h07F, 5'd9, 5'd10), 1'b1,
          alu_exp(F_ADD, 1'b1, 5'd9, 5'd10, 1'b1, 64'h7F));
    // Logical class, full-throughput stream
    cycle("and", 1'b1, enc(1'b0, 1'b0, LOGIC, 1'b0, 12'h0F0, 5'd2, 5'd6), 1'b1,
          alu_exp(F_AND, 1'b0, 5'd2, 5'd6, 1'b1, 64'hF0));
    cycle("orr", 1'b1, enc(1'b0, 1'b1, LOGIC, 1'b0, 12'h001, 5'd7, 5'd8), 1'b1,
          alu_exp(F_ORR, 1'b0, 5'd7, 5'd8, 1'b1, 64'h1));
    cycle("eor", 1'b1, enc(1'b1, 1'b0, LOGIC, 1'b0, 12'hA5A, 5'd30, 5'd0), 1'b1,
          alu_exp(F_EOR, 1'b0, 5'd30, 5'd0, 1'b1, 64'hA5A));
    cycle("ands", 1'b1, enc(1'b1, 1'b1, LOGIC, 1'b0, 12'h800, 5'd4, 5'd5), 1'b1,
          alu_exp(F_AND, 1'b1, 5'd4, 5'd5, 1'b1, 64'h800));
    cycle("tst", 1'b1, enc(1'b1, 1'b1, LOGIC, 1'b0, 12'h003, 5'd11, 5'd31), 1'b1,
          alu_exp(F_AND, 1'b1, 5'd11, 5'd31, 1'b0, 64'h3));
    // Undecodable class: NOP word, still counted
    cycle("badcls", 1'b1, enc(1'b0, 1'b0, 6'b000000, 1'b0, 12'h123, 5'd1, 5'd2), 1'b1, nop_exp());
    cycle("drain1", 1'b0, '0, 1'b1, idle);

    // Back-pressure: A accepted, B stalls until cw_ready rises
    cycle("bp_a", 1'b1, enc(1'b0, 1'b0, ARITH, 1'b0, 12'd17, 5'd12, 5'd13), 1'b0,
          alu_exp(F_ADD, 1'b0, 5'd12, 5'd13, 1'b1, 64'd17));
    w = enc(1'b1, 1'b0, ARITH, 1'b0, 12'd34, 5'd14, 5'd15);
    e = alu_exp(F_SUB, 1'b0, 5'd14, 5'd15, 1'b1, 64'd34);
    cycle("bp_b_stall", 1'b1, w, 1'b0, e);
    check("bp.in_ready_low", 64'(in_ready), 64'd0);
    cycle("bp_b_hold", 1'b1, w, 1'b0, e);
    cycle("bp_b_accept", 1'b1, w, 1'b1, e);
    cycle("bp_b_out", 1'b0, '0, 1'b1, idle);

    // Shift bit on the arithmetic class
`ifdef I_ARITH_SHIFT_EN
    e = alu_exp(F_ADD, 1'b0, 5'd2, 5'd3, 1'b1, 64'h1000);
`else
    e = nop_exp();
`endif
    cycle("shift", 1'b1, enc(1'b0, 1'b0, ARITH, 1'b1, 12'd1, 5'd2, 5'd3), 1'b1, e);
    cycle("shift_out", 1'b0, '0, 1'b1, idle);

    // Reset while a word is held
    cycle("pre_rst", 1'b1, enc(1'b0, 1'b0, ARITH, 1'b0, 12'd9, 5'd1, 5'd1), 1'b0,
          alu_exp(F_ADD, 1'b0, 5'd1, 5'd1, 1'b1, 64'd9));
    check("pre_rst.cw_valid", 64'(cw_valid), 64'd1);
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check("midrst.cw_valid", 64'(cw_valid), 64'd0);
    check("midrst.uop_count", 64'(uop_count), 64'd0);
    check("midrst.ctrl_word", 64'(ctrl_word), 64'd0);
    sb.delete();
    model_full = 1'b0;
    model_cnt  = '0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst.in_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    cycle("orri", 1'b1, enc(1'b0, 1'b1, LOGIC, 1'b0, 12'h055, 5'd20, 5'd21), 1'b1,
          alu_exp(F_ORR, 1'b0, 5'd20, 5'd21, 1'b1, 64'h55));
    cycle("orri_out", 1'b0, '0, 1'b1, idle);

    // Counter wrap: stream accepts up to 0xFFFF, then one more wraps to 0
    w = enc(1'b0, 1'b0, ARITH, 1'b0, 12'd1, 5'd1, 5'd2);
    e = alu_exp(F_ADD, 1'b0, 5'd1, 5'd2, 1'b1, 64'd1);
    while (model_cnt != 16'hFFFF) cycle("stream", 1'b1, w, 1'b1, e);
    check("wrap.pre", 64'(uop_count), 64'hFFFF);
    cycle("wrap", 1'b1, w, 1'b1, e);
    check("wrap.zero", 64'(uop_count), 64'd0);
    cycle("wrap_out", 1'b0, '0, 1'b1, idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
